// File: rtl/intr_pend_arb.sv
// Interrupt pending capture and fixed-priority arbiter with an IDLE/REQ/SERV handshake to the core.
// Define INTR_EDGE_TRIG_EN for edge-triggered capture; the default build is level-sensitive.
module intr_pend_arb #(
  parameter int NUM_INTR = 128,
  parameter int ID_W     = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_INTR-1:0] intr_bundle_i,
  input  logic                global_ie_i,
  input  logic                irq_ack_i,
  input  logic                irq_done_i,
  output logic                irq_req_o,
  output logic [ID_W-1:0]     irq_id_o,
  output logic                in_service_o,
  output logic [NUM_INTR-1:0] pending_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t              state_reg, state_next;
  logic                req_reg, req_next;
  logic [ID_W-1:0]     id_reg, id_next;
  logic                serv_reg, serv_next;
  logic [NUM_INTR-1:0] sync_q;
  logic [NUM_INTR-1:0] pending;
  logic [ID_W-1:0]     winner;
  logic                any_pending;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= intr_bundle_i;
    end
  end

`ifdef INTR_EDGE_TRIG_EN
  logic [NUM_INTR-1:0] prev_q;
  logic [NUM_INTR-1:0] pending_reg, pending_next;
  logic [NUM_INTR-1:0] clr_mask;

  // A new rising edge on the acked source in the same cycle must survive the clear.
  always_comb begin
    clr_mask = '0;
    if (state_reg == REQ && irq_ack_i) begin
      clr_mask = {{(NUM_INTR-1){1'b0}}, 1'b1} << irq_id_o;
    end
    pending_next = (pending_reg & ~clr_mask) | (sync_q & ~prev_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q      <= '0;
      pending_reg <= '0;
    end else begin
      prev_q      <= sync_q;
      pending_reg <= pending_next;
    end
  end

  assign pending   = pending_reg;
  assign pending_o = pending_reg;
`else
  // Level mode: the synchronised line is the pending bit; the source must deassert itself.
  assign pending   = sync_q;
  assign pending_o = sync_q;
`endif

  always_comb begin
    winner      = '0;
    any_pending = |pending;
    for (int i = NUM_INTR - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      id_reg    <= '0;
      serv_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      id_reg    <= id_next;
      serv_reg  <= serv_next;
    end
  end

  // The ID is only loaded on IDLE->REQ, so it stays frozen in REQ/SERV and holds in IDLE.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    id_next    = id_reg;
    serv_next  = serv_reg;
    case (state_reg)
      IDLE: begin
        if (global_ie_i && any_pending) begin
          state_next = REQ;
          req_next   = 1'b1;
          id_next    = winner;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_next = SERV;
          req_next   = 1'b0;
          serv_next  = 1'b1;
        end else if (!global_ie_i) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      SERV: begin
        if (irq_done_i) begin
          state_next = IDLE;
          serv_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
        serv_next  = 1'b0;
      end
    endcase
  end

  assign irq_req_o    = req_reg;
  assign irq_id_o     = id_reg;
  assign in_service_o = serv_reg;

endmodule
